// File: rtl/serializer_pkg.sv
// Shared types and defaults for the byte serializer.
package serializer_pkg;

  // Transmit FSM states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    HIGH = 3'd3,
    LOW  = 3'd4
  } state_t;

  localparam int DEF_DEPTH       = 8;
  localparam int DEF_HALF_CYCLES = 10;

endpackage

// File: rtl/byte_fifo.sv
// Byte queue with wrapping pointers and an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo
  import serializer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clock1M,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign data    = mem[rd_ptr];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clock1M) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/serializer_out.sv
// Byte-queued, MSB-first serial transmitter with a strobed handshake.
//
// state | meaning
// IDLE  | nothing to send; pops the queue head as soon as one exists
// LOAD  | one cycle after a pop; resets the bit index to 7
// WAIT  | holds off while the receiver signals stall
// HIGH  | strobe high, current bit presented, HALF_CYCLES cycles
// LOW   | strobe low, bit held, HALF_CYCLES cycles; then next bit/byte
module serializer_out
  import serializer_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int HALF_CYCLES = DEF_HALF_CYCLES
) (
  input  logic       clock1M,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       enqueue_in,
  input  logic       stall_in,
  output logic       data_out,
  output logic       write_out,
  output logic       status_out,
  output logic       empty_out
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam int            TW       = $clog2(HALF_CYCLES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] HC_M1    = TW'(HALF_CYCLES - 1);

  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [TW-1:0] timer;

  logic          enq_prev;
  logic          armed;
  logic          enq_edge;
  logic          push;
  logic          pop;
  logic          last_low;

  logic [7:0]    fifo_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // armed stays low after reset until enqueue_in is seen low, so a level
  // already high at reset release cannot masquerade as a new request
  assign enq_edge = enqueue_in & ~enq_prev & armed;
  assign last_low = (state == LOW) && (timer == '0) && (bit_idx == 3'd0);
  assign pop      = ((state == IDLE) || last_low) && !fifo_empty;
  assign push     = enq_edge & (~fifo_full | pop);

  assign status_out = (fifo_count == FULL_CNT);
  assign empty_out  = fifo_empty && (state == IDLE);

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock1M (clock1M),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .din     (data_in),
    .data    (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Enqueue edge detector
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      enq_prev <= 1'b0;
      armed    <= 1'b0;
    end else begin
      enq_prev <= enqueue_in;
      armed    <= armed | ~enqueue_in;
    end
  end

  // Transmit FSM with shifter, phase timer and registered outputs
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      timer     <= '0;
      data_out  <= 1'b0;
      write_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shift <= fifo_data;
            state <= LOAD;
          end
        end
        LOAD: begin
          bit_idx <= 3'd7;
          state   <= WAIT;
        end
        WAIT: begin
          if (!stall_in) begin
            write_out <= 1'b1;
            data_out  <= shift[bit_idx];
            timer     <= HC_M1;
            state     <= HIGH;
          end
        end
        HIGH: begin
          if (timer == '0) begin
            write_out <= 1'b0;
            timer     <= HC_M1;
            state     <= LOW;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        LOW: begin
          if (timer == '0) begin
            if (bit_idx != 3'd0) begin
              bit_idx <= bit_idx - 1'b1;
              state   <= WAIT;
            end else if (!fifo_empty) begin
              shift <= fifo_data;
              state <= LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
